msa_field_decode: RTL and testbench

- Registered decode stage directly downstream of the MSA instruction-format classifier.
- Consumes the 32-bit instruction word and its 4-bit format code. Extracts the register specifiers, data format (df), operation field and extended immediate, then hands them to the SIMD issue/register-read stage.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so the input ready signal is not combinationally dependent on the output ready signal. Synchronous flush for branch redirect.

---
 rtl/msa_field_decode.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_msa_field_decode.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msa_field_decode.sv
// msa_field_decode: registered MSA field decode with 2-entry skid buffer.
// Optional MSA_DECODE_PERF_EN adds issued/stall performance counters.
module msa_field_decode #(
    parameter int IMM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [3:0]       in_fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_fmt,
    output logic [4:0]       out_op,
    output logic [4:0]       out_wd,
    output logic [4:0]       out_ws,
    output logic [4:0]       out_wt,
    output logic [1:0]       out_df,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_illegal
`ifdef MSA_DECODE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam logic [3:0] FMT_I8   = 4'd0;
    localparam logic [3:0] FMT_I5   = 4'd1;
    localparam logic [3:0] FMT_I10  = 4'd2;
    localparam logic [3:0] FMT_BIT  = 4'd3;
    localparam logic [3:0] FMT_3R   = 4'd4;
    localparam logic [3:0] FMT_ELM  = 4'd5;
    localparam logic [3:0] FMT_3RF  = 4'd6;
    localparam logic [3:0] FMT_2R   = 4'd7;
    localparam logic [3:0] FMT_2RF  = 4'd8;
    localparam logic [3:0] FMT_VEC  = 4'd9;
    localparam logic [3:0] FMT_MI10 = 4'd10;
    localparam logic [3:0] FMT_BR   = 4'd11;

    typedef struct packed {
        logic [3:0]       fmt;
        logic [4:0]       op;
        logic [4:0]       wd;
        logic [4:0]       ws;
        logic [4:0]       wt;
        logic [1:0]       df;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t  state_q;
    state_t  state_d;
    logic    in_ready_q;
    logic    in_xfer;
    logic    out_xfer;
    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;

    logic [IMM_W-1:0] i5_sext;
    logic [IMM_W-1:0] i5_zext;
    logic [IMM_W-1:0] i10_sext;
    logic [IMM_W-1:0] mi10_base;
    logic [IMM_W-1:0] mi10_off;
    logic [IMM_W-1:0] br_off;
    logic             unused_bits;

    assign i5_sext   = IMM_W'($signed(in_instr[20:16]));
    assign i5_zext   = IMM_W'(in_instr[20:16]);
    assign i10_sext  = IMM_W'($signed(in_instr[20:11]));
    assign mi10_base = IMM_W'($signed(in_instr[25:16]));
    assign mi10_off  = mi10_base << in_instr[1:0];
    assign br_off    = IMM_W'($signed(in_instr[15:0])) << 2;

    // Opcode bits above the MSA minor fields are classified upstream.
    assign unused_bits = ^in_instr[31:26];

    // Decode the incoming word into a bundle according to its format.
    always_comb begin
        dec     = '0;
        dec.fmt = in_fmt;
        dec.ws  = in_instr[15:11];
        dec.wd  = in_instr[10:6];
        unique case (1'b1)
            (in_fmt == FMT_I8): begin
                dec.op  = {3'b0, in_instr[25:24]};
                dec.imm = IMM_W'(in_instr[23:16]);
            end
            (in_fmt == FMT_I5): begin
                dec.op = {2'b0, in_instr[25:23]};
                dec.df = in_instr[22:21];
                if (in_instr[25:23] inside {3'd2, 3'd4, 3'd5}) begin
                    dec.imm = i5_sext;
                end else begin
                    dec.imm = i5_zext;
                end
            end
            (in_fmt == FMT_I10): begin
                dec.op  = {2'b0, in_instr[25:23]};
                dec.df  = in_instr[22:21];
                dec.imm = i10_sext;
            end
            (in_fmt == FMT_BIT): begin
                dec.op = {2'b0, in_instr[25:23]};
                priority casez (in_instr[22:16])
                    7'b0??????: begin
                        dec.df  = 2'd3;
                        dec.imm = IMM_W'(in_instr[21:16]);
                    end
                    7'b10?????: begin
                        dec.df  = 2'd2;
                        dec.imm = IMM_W'(in_instr[20:16]);
                    end
                    7'b110????: begin
                        dec.df  = 2'd1;
                        dec.imm = IMM_W'(in_instr[19:16]);
                    end
                    7'b1110???: begin
                        dec.df  = 2'd0;
                        dec.imm = IMM_W'(in_instr[18:16]);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            (in_fmt == FMT_3R): begin
                dec.op = {2'b0, in_instr[25:23]};
                dec.df = in_instr[22:21];
                dec.wt = in_instr[20:16];
            end
            (in_fmt == FMT_ELM): begin
                dec.op = {1'b0, in_instr[25:22]};
                priority casez (in_instr[21:16])
                    6'b00????: begin
                        dec.df  = 2'd0;
                        dec.imm = IMM_W'(in_instr[19:16]);
                    end
                    6'b100???: begin
                        dec.df  = 2'd1;
                        dec.imm = IMM_W'(in_instr[18:16]);
                    end
                    6'b1100??: begin
                        dec.df  = 2'd2;
                        dec.imm = IMM_W'(in_instr[17:16]);
                    end
                    6'b11100?: begin
                        dec.df  = 2'd3;
                        dec.imm = IMM_W'(in_instr[16]);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            (in_fmt == FMT_3RF): begin
                dec.op = {1'b0, in_instr[25:22]};
                dec.df = {1'b1, in_instr[21]};
                dec.wt = in_instr[20:16];
            end
            (in_fmt == FMT_2R): begin
                dec.op = {2'b0, in_instr[20:18]};
                dec.df = in_instr[17:16];
            end
            (in_fmt == FMT_2RF): begin
                dec.op = {1'b0, in_instr[20:17]};
                dec.df = {1'b1, in_instr[16]};
            end
            (in_fmt == FMT_VEC): begin
                dec.op = in_instr[25:21];
                dec.wt = in_instr[20:16];
            end
            (in_fmt == FMT_MI10): begin
                dec.op  = {1'b0, in_instr[5:2]};
                dec.df  = in_instr[1:0];
                dec.imm = mi10_off;
            end
            (in_fmt == FMT_BR): begin
                dec.op  = in_instr[25:21];
                dec.wt  = in_instr[20:16];
                dec.imm = br_off;
            end
            default: begin
                dec.ws      = '0;
                dec.wd      = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Skid buffer occupancy: next state from the two handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) state_d = S_ONE;
            end
            S_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = S_FULL;
                end else if (!in_xfer && out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_xfer) state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Occupancy register and registered in_ready; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Data path: output register and skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_xfer) out_q <= dec;
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_q <= dec;
                    end else if (in_xfer) begin
                        skid_q <= dec;
                    end
                end
                S_FULL: begin
                    if (out_xfer) out_q <= skid_q;
                end
                default: begin
                    out_q <= out_q;
                end
            endcase
        end
    end

    assign out_fmt     = out_q.fmt;
    assign out_op      = out_q.op;
    assign out_wd      = out_q.wd;
    assign out_ws      = out_q.ws;
    assign out_wt      = out_q.wt;
    assign out_df      = out_q.df;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

`ifdef MSA_DECODE_PERF_EN
    // Issue and stall counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (out_xfer && !flush) perf_issued <= perf_issued + 32'd1;
            if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_msa_field_decode.sv
// tb_msa_field_decode: vector table, directed handshake sequences and
// randomized traffic against a scoreboard with a behavioural decode model.
module tb_msa_field_decode;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [4:0]  op;
        logic [4:0]  wd;
        logic [4:0]  ws;
        logic [4:0]  wt;
        logic [1:0]  df;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  fmt;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [3:0]  in_fmt;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_fmt;
    logic [4:0]  out_op;
    logic [4:0]  out_wd;
    logic [4:0]  out_ws;
    logic [4:0]  out_wt;
    logic [1:0]  out_df;
    logic [31:0] out_imm;
    logic        out_illegal;
`ifdef MSA_DECODE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int popped = 0;
    exp_t q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    msa_field_decode #(.IMM_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_fmt(in_fmt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_fmt(out_fmt),
        .out_op(out_op),
        .out_wd(out_wd),
        .out_ws(out_ws),
        .out_wt(out_wt),
        .out_df(out_df),
        .out_imm(out_imm),
        .out_illegal(out_illegal)
`ifdef MSA_DECODE_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall(perf_stall)
`endif
    );

    function automatic longint sext(longint v, int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Behavioural decode model built from the format rules.
    function automatic exp_t ref_decode(logic [31:0] w, logic [3:0] f);
        exp_t   e;
        int     k;
        longint v;
        e     = '0;
        e.fmt = f;
        if (f >= 4'd12) begin
            e.illegal = 1'b1;
            return e;
        end
        e.ws = w[15:11];
        e.wd = w[10:6];
        v = 0;
        case (f)
            4'd0: begin
                e.op = 5'(w[25:24]);
                v = longint'(w[23:16]);
            end
            4'd1: begin
                e.op = 5'(w[25:23]);
                e.df = w[22:21];
                v = longint'(w[20:16]);
                if (e.op == 2 || e.op == 4 || e.op == 5) v = sext(v, 5);
            end
            4'd2: begin
                e.op = 5'(w[25:23]);
                e.df = w[22:21];
                v = sext(longint'(w[20:11]), 10);
            end
            4'd3: begin
                e.op = 5'(w[25:23]);
                k = 0;
                while (k < 7 && w[22-k]) k++;
                if (k <= 3) begin
                    e.df = 2'(3 - k);
                    v = longint'(w[22:16]) % (longint'(1) << (6 - k));
                end else begin
                    e.illegal = 1'b1;
                end
            end
            4'd4: begin
                e.op = 5'(w[25:23]);
                e.df = w[22:21];
                e.wt = w[20:16];
            end
            4'd5: begin
                e.op = 5'(w[25:22]);
                k = 0;
                while (k < 6 && w[21-k]) k++;
                if (k <= 3 && !w[20-k]) begin
                    e.df = 2'(k);
                    v = longint'(w[21:16]) % (longint'(1) << (4 - k));
                end else begin
                    e.illegal = 1'b1;
                end
            end
            4'd6: begin
                e.op = 5'(w[25:22]);
                e.df = 2'(2 + w[21]);
                e.wt = w[20:16];
            end
            4'd7: begin
                e.op = 5'(w[20:18]);
                e.df = w[17:16];
            end
            4'd8: begin
                e.op = 5'(w[20:17]);
                e.df = 2'(2 + w[16]);
            end
            4'd9: begin
                e.op = w[25:21];
                e.wt = w[20:16];
            end
            4'd10: begin
                e.op = 5'(w[5:2]);
                e.df = w[1:0];
                v = sext(longint'(w[25:16]), 10) * (longint'(1) << w[1:0]);
            end
            default: begin
                e.op = w[25:21];
                e.wt = w[20:16];
                v = sext(longint'(w[15:0]), 16) * 4;
            end
        endcase
        e.imm = v[31:0];
        return e;
    endfunction

    function automatic exp_t got();
        exp_t g;
        g.fmt = out_fmt;
        g.op = out_op;
        g.wd = out_wd;
        g.ws = out_ws;
        g.wt = out_wt;
        g.df = out_df;
        g.imm = out_imm;
        g.illegal = out_illegal;
        return g;
    endfunction

    function automatic exp_t mk(logic [3:0] f, logic [4:0] op, logic [4:0] wd,
                                logic [4:0] ws, logic [4:0] wt, logic [1:0] df,
                                logic [31:0] imm, logic ill);
        exp_t e;
        e.fmt = f;
        e.op = op;
        e.wd = wd;
        e.ws = ws;
        e.wt = wt;
        e.df = df;
        e.imm = imm;
        e.illegal = ill;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input exp_t e);
        exp_t g;
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got fmt=%0d op=%0d wd=%0d ws=%0d wt=%0d df=%0d imm=%h ill=%0b expected fmt=%0d op=%0d wd=%0d ws=%0d wt=%0d df=%0d imm=%h ill=%0b",
                     nm, g.fmt, g.op, g.wd, g.ws, g.wt, g.df, g.imm, g.illegal,
                     e.fmt, e.op, e.wd, e.ws, e.wt, e.df, e.imm, e.illegal);
        end
    endtask

    // One clock: check occupancy, score transfers, then advance.
    task automatic tick();
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                chk_b("scoreboard", q.pop_front());
                popped++;
            end
            if (in_valid && in_ready) q.push_back(ref_decode(in_instr, in_fmt));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_fmt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic offer(input logic [31:0] w, input logic [3:0] f);
        in_valid = 1'b1;
        in_instr = w;
        in_fmt = f;
    endtask

    initial begin
        int start;
        int budget;

        vecs.push_back('{32'h7843104E, 4'd4, mk(4'd4, 5'd0, 5'd1, 5'd2, 5'd3, 2'd2, 32'h0, 1'b0)});
        vecs.push_back('{32'h7B3FF947, 4'd2, mk(4'd2, 5'd6, 5'd5, 5'd31, 5'd0, 2'd1, 32'hFFFFFFFF, 1'b0)});
        vecs.push_back('{32'h0000FFFE, 4'd11, mk(4'd11, 5'd0, 5'd31, 5'd31, 5'd0, 2'd0, 32'hFFFFFFF8, 1'b0)});
        vecs.push_back('{32'h00780000, 4'd3, mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 32'h0, 1'b1)});
        vecs.push_back('{32'hFFFFFFFF, 4'd13, mk(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 32'h0, 1'b1)});
        vecs.push_back('{32'h01AB0000, 4'd0, mk(4'd0, 5'd1, 5'd0, 5'd0, 5'd0, 2'd0, 32'hAB, 1'b0)});
        vecs.push_back('{32'h01700000, 4'd1, mk(4'd1, 5'd2, 5'd0, 5'd0, 5'd0, 2'd3, 32'hFFFFFFF0, 1'b0)});
        vecs.push_back('{32'h00F00000, 4'd1, mk(4'd1, 5'd1, 5'd0, 5'd0, 5'd0, 2'd3, 32'h10, 1'b0)});
        vecs.push_back('{32'h03D50000, 4'd3, mk(4'd3, 5'd7, 5'd0, 5'd0, 5'd0, 2'd2, 32'h15, 1'b0)});
        vecs.push_back('{32'h02720000, 4'd5, mk(4'd5, 5'd9, 5'd0, 5'd0, 5'd0, 2'd2, 32'h2, 1'b0)});
        vecs.push_back('{32'h00100000, 4'd5, mk(4'd5, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 32'h0, 1'b1)});
        vecs.push_back('{32'h03FF0017, 4'd10, mk(4'd10, 5'd5, 5'd0, 5'd0, 5'd0, 2'd3, 32'hFFFFFFF8, 1'b0)});
        vecs.push_back('{32'h00153A40, 4'd8, mk(4'd8, 5'd10, 5'd9, 5'd7, 5'd0, 2'd3, 32'h0, 1'b0)});
        vecs.push_back('{32'h03E40000, 4'd9, mk(4'd9, 5'd31, 5'd0, 5'd0, 5'd4, 2'd0, 32'h0, 1'b0)});

        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk_b("rst_data", '0);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            offer(vecs[i].instr, vecs[i].fmt);
            tick();
            in_valid = 1'b0;
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk_b($sformatf("vec%0d", i), vecs[i].e);
            tick();
        end

        out_ready = 1'b0;
        start = popped;
        offer(32'h7843104E, 4'd4);
        tick();
        offer(32'h7B3FF947, 4'd2);
        tick();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        offer(32'h03E40000, 4'd9);
        tick();
        tick();
        chk("bp_held_in_ready", 64'(in_ready), 64'd0);
        chk_b("bp_head", ref_decode(32'h7843104E, 4'd4));
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_popped", 64'(popped - start), 64'd3);
        chk("bp_empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        offer(32'h01AB0000, 4'd0);
        tick();
        offer(32'h00F00000, 4'd1);
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        offer(32'h03D50000, 4'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_dropped", 64'(out_valid), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_instr = $urandom();
            in_fmt = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 40) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            tick();
            budget++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

`ifdef MSA_DECODE_PERF_EN
        do_reset();
        chk("perf_rst_issued", 64'(perf_issued), 64'd0);
        chk("perf_rst_stall", 64'(perf_stall), 64'd0);
        offer(32'h7843104E, 4'd4);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            offer(32'h01AB0000 + 32'(n), 4'd0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("perf_issued", 64'(perf_issued), 64'd4);
        chk("perf_stall", 64'(perf_stall), 64'd3);
        do_reset();
        chk("perf_clr_issued", 64'(perf_issued), 64'd0);
        chk("perf_clr_stall", 64'(perf_stall), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
